mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
- Memory-side stage directly downstream of the CPU core. Consumes the core's mem_addr, writedata and MEM_WR_S, and produces its mem_out.
- Decodes each access to either the external block RAM or a bank of memory-mapped I/O registers: LEDs, switches, buttons, hex display, interval timer and cycle counter.
- Returns read data with a fixed 1-cycle latency for both regions, matching synchronous BRAM.

Parameters:
- WIDTH, 16, data and address width.
- IO_PAGE, 4'hF, value of mem_addr[15:12] that selects MMIO; any other value selects BRAM.
- PRESCALE, 50000, clk cycles per timer tick (1 ms at 50 MHz).
- NSW, 10, number of switches and LEDs.
- NBTN, 4, number of buttons.

Ports:
- clk  in  1  50 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  in  WIDTH  CPU address.
- writedata  in  WIDTH  CPU write data.
- MEM_WR_S  in  1  CPU write enable.
- mem_out  out  WIDTH  read data to CPU.
- bram_addr  out  WIDTH  BRAM address, equal to mem_addr.
- bram_din  out  WIDTH  BRAM write data, equal to writedata.
- bram_we  out  1  BRAM write enable.
- bram_dout  in  WIDTH  BRAM synchronous read data.
- sw  in  NSW  raw switches, asynchronous.
- btn  in  NBTN  raw buttons, active-high, asynchronous.
- led  out  NSW  LED register.
- hex_val  out  WIDTH  value driven to the 7-segment driver.

Behaviour:
- Decode: io_sel = (mem_addr[15:12] == IO_PAGE).
  - bram_we = MEM_WR_S & ~io_sel, combinational.
  - MMIO register index = mem_addr[3:0]; mem_addr[11:4] is ignored, so registers alias across the page.
- Read latency: io_sel_q and idx_q are registered each cycle. mem_out is combinational from these:
  - io_sel_q = 0: mem_out = bram_dout.
  - io_sel_q = 1: mem_out = the MMIO register value as it is now (it may reflect a same-cycle update).
- MMIO writes take effect at the clock edge while MEM_WR_S = 1.
- MMIO register map (unlisted indices read 0, writes ignored):
  - 0 LED, RW, bits [NSW-1:0].
  - 1 SW, RO. Value after a 2-flop synchroniser, zero-extended.
  - 2 BTN, sticky rising-edge flags. Write 1 to a bit to clear it. If set and clear hit the same bit in the same cycle, set wins.
  - 3 HEX, RW.
  - 4 TLOAD, RW, timer reload value.
  - 5 TCOUNT, RO, current timer count.
  - 6 TCTRL:
    - bit0 EN, RW.
    - bit1 AUTO, RW.
    - bit15 EXP, sticky; write 1 to clear. If set and clear coincide, set wins.
  - 7 CYCLE, RO, free-running 16-bit counter, +1 per clk, wraps at 0xFFFF->0.
- Buttons: 2-flop synchroniser, then edge detect on synced & ~prev. Sets the corresponding BTN bit.
- Timer:
  - Writing TCTRL with EN going 0->1 loads TCOUNT <= TLOAD and clears the prescaler.
  - While EN=1, the prescaler counts 0..PRESCALE-1; one tick is emitted on wrap.
  - On a tick with TCOUNT > 1: TCOUNT decrements.
  - On a tick with TCOUNT == 1 (or TCOUNT == 0): TCOUNT <= 0 and EXP is set.
    - AUTO=1: reload TCOUNT <= TLOAD on the same edge.
    - AUTO=0: clear EN.
  - TLOAD == 0 with EN=1: EXP is set on the first tick.
  - Writing TLOAD while running does not change TCOUNT until the next reload.
  - EN=0 freezes both TCOUNT and the prescaler.
- Reset (async, active-low). The following are cleared to 0 immediately:
  - led, hex_val, mem_out selects (io_sel_q, idx_q)
  - BTN, TLOAD, TCOUNT, TCTRL, CYCLE
  - prescaler, synchroniser flops
  - bram_we = MEM_WR_S & ~io_sel remains combinational throughout.
- Reset asserted mid-countdown aborts the timer. There is no pending state after release.

Optional Feature:
- Macro: MEM_IO_BTN_DEBOUNCE_EN.
- Defined: each synchronised button must be stable for 2^16 clk cycles before its debounced level changes. Edge detect operates on the debounced level.
- Undefined: edge detect operates on the synchronised level directly, with no extra latency.

Decomposition:
- Shared package holds:
  - MMIO index constants (IDX_LED .. IDX_CYCLE)
  - TCTRL bit positions (TC_EN=0, TC_AUTO=1, TC_EXP=15)
  - IO_PAGE default
- One natural sub-module: io_timer, containing the prescaler, TCOUNT, EN/AUTO/EXP logic and tick generation. It is instantiated once.
- Synchronisers and debounce stay inline.

Test Plan:
- Write 0x1234 to addr 0x0040 with MEM_WR_S=1 -> bram_we=1, bram_addr=0x0040; read 0x0040 next cycle -> mem_out=bram_dout one cycle after address.
- Write 0x03FF to 0xF000, read back 0xF000 -> led=0x3FF, mem_out=0x03FF after 1 cycle; bram_we stays 0.
- Drive btn[2] 0->1 -> BTN reads 0x0004 at sync latency; write 0x0004 to 0xF002 -> reads 0x0000.
- PRESCALE=4, TLOAD=3, TCTRL=0x0001 -> TCOUNT 3,2,1,0 every 4 clk; EXP set; EN cleared; TCOUNT holds 0.
- Same with TCTRL=0x0003 -> TCOUNT reloads to 3 on expiry; EXP stays set until 0x8000 is written to 0xF006.
- Assert reset mid-countdown with led=0x155 -> led, TCOUNT, TCTRL, CYCLE all 0 immediately; counting resumes from CYCLE=0 after release.

Source files
------------

// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the memory/MMIO bridge: register map, TCTRL bit positions, MMIO page.
package mem_io_bridge_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned DB_W  = 16;

  localparam logic [3:0] IO_PAGE_DEF = 4'hF;

  localparam logic [IDX_W-1:0] IDX_LED    = 4'd0;
  localparam logic [IDX_W-1:0] IDX_SW     = 4'd1;
  localparam logic [IDX_W-1:0] IDX_BTN    = 4'd2;
  localparam logic [IDX_W-1:0] IDX_HEX    = 4'd3;
  localparam logic [IDX_W-1:0] IDX_TLOAD  = 4'd4;
  localparam logic [IDX_W-1:0] IDX_TCOUNT = 4'd5;
  localparam logic [IDX_W-1:0] IDX_TCTRL  = 4'd6;
  localparam logic [IDX_W-1:0] IDX_CYCLE  = 4'd7;

  localparam int unsigned TC_EN   = 0;
  localparam int unsigned TC_AUTO = 1;
  localparam int unsigned TC_EXP  = 15;

endpackage

// File: rtl/mem_io_bridge_io_timer.sv
// Interval timer: prescaler, reload/countdown register and EN/AUTO/EXP control bits.
module mem_io_bridge_io_timer
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tload_we,
  input  logic             i_tctrl_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_tload,
  output logic [WIDTH-1:0] o_tcount,
  output logic [WIDTH-1:0] o_tctrl
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_tload;
  logic [WIDTH-1:0] r_count;
  logic             r_en;
  logic             r_auto;
  logic             r_exp;

  logic w_tick;
  logic w_start;
  logic w_last;
  logic w_expire;

  assign w_tick   = r_en && (r_pre == PRE_LAST);
  assign w_start  = i_tctrl_we && i_wdata[TC_EN] && !r_en;
  assign w_last   = (r_count <= WIDTH'(1));
  assign w_expire = w_tick && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_tload <= '0;
      r_count <= '0;
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_exp   <= 1'b0;
    end else begin
      if (i_tload_we) r_tload <= i_wdata;

      // An EN 0->1 write restarts the countdown from the current reload value.
      if (w_start) begin
        r_pre   <= '0;
        r_count <= r_tload;
      end else if (r_en) begin
        if (w_tick) begin
          r_pre <= '0;
          if (!w_last)     r_count <= r_count - WIDTH'(1);
          else if (r_auto) r_count <= r_tload;
          else             r_count <= '0;
        end else begin
          r_pre <= r_pre + PW'(1);
        end
      end

      if (i_tctrl_we) begin
        r_en   <= i_wdata[TC_EN];
        r_auto <= i_wdata[TC_AUTO];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      // Set has priority over a coincident write-1-to-clear.
      if (w_expire)                           r_exp <= 1'b1;
      else if (i_tctrl_we && i_wdata[TC_EXP]) r_exp <= 1'b0;
    end
  end

  always_comb begin
    o_tctrl          = '0;
    o_tctrl[TC_EN]   = r_en;
    o_tctrl[TC_AUTO] = r_auto;
    o_tctrl[TC_EXP]  = r_exp;
  end

  assign o_tload  = r_tload;
  assign o_tcount = r_count;

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory stage: decodes accesses to BRAM or the MMIO register bank, 1-cycle read latency.
// Optional MEM_IO_BTN_DEBOUNCE_EN adds a 2^16-cycle stability filter ahead of button edge detect.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter logic [3:0]  IO_PAGE  = IO_PAGE_DEF,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned NSW      = 10,
  parameter int unsigned NBTN     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             MEM_WR_S,
  output logic [WIDTH-1:0] mem_out,
  output logic [WIDTH-1:0] bram_addr,
  output logic [WIDTH-1:0] bram_din,
  output logic             bram_we,
  input  logic [WIDTH-1:0] bram_dout,
  input  logic [NSW-1:0]   sw,
  input  logic [NBTN-1:0]  btn,
  output logic [NSW-1:0]   led,
  output logic [WIDTH-1:0] hex_val
);

  logic             w_io_sel;
  logic             w_io_wr;
  logic [IDX_W-1:0] w_idx;
  logic             w_addr_unused;
  logic             w_led_we;
  logic             w_hex_we;
  logic             w_btn_we;
  logic             w_tload_we;
  logic             w_tctrl_we;
  logic [NBTN-1:0]  w_btn_lvl;
  logic [NBTN-1:0]  w_btn_rise;
  logic [NBTN-1:0]  w_btn_clr;
  logic [WIDTH-1:0] w_tload;
  logic [WIDTH-1:0] w_tcount;
  logic [WIDTH-1:0] w_tctrl;
  logic [WIDTH-1:0] w_mmio_rd;

  logic             r_io_sel_q;
  logic [IDX_W-1:0] r_idx_q;
  logic [NSW-1:0]   r_led;
  logic [WIDTH-1:0] r_hex;
  logic [WIDTH-1:0] r_cycle;
  logic [NSW-1:0]   r_sw_s1;
  logic [NSW-1:0]   r_sw_s2;
  logic [NBTN-1:0]  r_btn_s1;
  logic [NBTN-1:0]  r_btn_s2;
  logic [NBTN-1:0]  r_btn_prev;
  logic [NBTN-1:0]  r_btn_flags;

  // Address decode; bits [11:4] are don't-care so the register bank aliases across the page.
  assign w_io_sel      = (mem_addr[15:12] == IO_PAGE);
  assign w_idx         = mem_addr[IDX_W-1:0];
  assign w_addr_unused = ^mem_addr[11:4];
  assign w_io_wr       = MEM_WR_S & w_io_sel;

  assign bram_we   = MEM_WR_S & ~w_io_sel;
  assign bram_addr = mem_addr;
  assign bram_din  = writedata;

  assign w_led_we   = w_io_wr && (w_idx == IDX_LED);
  assign w_btn_we   = w_io_wr && (w_idx == IDX_BTN);
  assign w_hex_we   = w_io_wr && (w_idx == IDX_HEX);
  assign w_tload_we = w_io_wr && (w_idx == IDX_TLOAD);
  assign w_tctrl_we = w_io_wr && (w_idx == IDX_TCTRL);

  assign w_btn_clr  = w_btn_we ? writedata[NBTN-1:0] : '0;
  assign w_btn_rise = w_btn_lvl & ~r_btn_prev;

`ifdef MEM_IO_BTN_DEBOUNCE_EN
  logic [DB_W-1:0] r_db_cnt [NBTN];
  logic [NBTN-1:0] r_btn_db;

  // Debounced level follows the synced input only after it has differed for 2^16 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBTN; i++) r_db_cnt[i] <= '0;
      r_btn_db <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (r_btn_s2[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == '1) begin
          r_btn_db[i] <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_btn_lvl = r_btn_db;
`else
  assign w_btn_lvl = r_btn_s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_io_sel_q  <= 1'b0;
      r_idx_q     <= '0;
      r_led       <= '0;
      r_hex       <= '0;
      r_cycle     <= '0;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_btn_s1    <= '0;
      r_btn_s2    <= '0;
      r_btn_prev  <= '0;
      r_btn_flags <= '0;
    end else begin
      r_io_sel_q <= w_io_sel;
      r_idx_q    <= w_idx;
      if (w_led_we) r_led <= writedata[NSW-1:0];
      if (w_hex_we) r_hex <= writedata;
      r_cycle    <= r_cycle + WIDTH'(1);
      r_sw_s1    <= sw;
      r_sw_s2    <= r_sw_s1;
      r_btn_s1   <= btn;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= w_btn_lvl;
      // New edges win over a coincident write-1-to-clear.
      r_btn_flags <= w_btn_rise | (r_btn_flags & ~w_btn_clr);
    end
  end

  mem_io_bridge_io_timer #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_io_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_tload_we (w_tload_we),
    .i_tctrl_we (w_tctrl_we),
    .i_wdata    (writedata),
    .o_tload    (w_tload),
    .o_tcount   (w_tcount),
    .o_tctrl    (w_tctrl)
  );

  // Read mux uses the registered index but live register contents.
  always_comb begin
    w_mmio_rd = '0;
    case (r_idx_q)
      IDX_LED:    w_mmio_rd = WIDTH'(r_led);
      IDX_SW:     w_mmio_rd = WIDTH'(r_sw_s2);
      IDX_BTN:    w_mmio_rd = WIDTH'(r_btn_flags);
      IDX_HEX:    w_mmio_rd = r_hex;
      IDX_TLOAD:  w_mmio_rd = w_tload;
      IDX_TCOUNT: w_mmio_rd = w_tcount;
      IDX_TCTRL:  w_mmio_rd = w_tctrl;
      IDX_CYCLE:  w_mmio_rd = r_cycle;
      default:    w_mmio_rd = '0;
    endcase
  end

  assign mem_out = r_io_sel_q ? w_mmio_rd : bram_dout;
  assign led     = r_led;
  assign hex_val = r_hex;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: BRAM path, MMIO registers, buttons, timer and reset.
module tb_mem_io_bridge;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NSW      = 10;
  localparam int unsigned NBTN     = 4;
  localparam int unsigned PRESCALE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] writedata;
  logic             MEM_WR_S;
  logic [WIDTH-1:0] mem_out;
  logic [WIDTH-1:0] bram_addr;
  logic [WIDTH-1:0] bram_din;
  logic             bram_we;
  logic [WIDTH-1:0] bram_dout;
  logic [NSW-1:0]   sw;
  logic [NBTN-1:0]  btn;
  logic [NSW-1:0]   led;
  logic [WIDTH-1:0] hex_val;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] bram_mem [256];
  logic [15:0] rd;
  logic [15:0] exp_cnt;

  mem_io_bridge #(
    .WIDTH    (WIDTH),
    .IO_PAGE  (4'hF),
    .PRESCALE (PRESCALE),
    .NSW      (NSW),
    .NBTN     (NBTN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .writedata (writedata),
    .MEM_WR_S  (MEM_WR_S),
    .mem_out   (mem_out),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .bram_dout (bram_dout),
    .sw        (sw),
    .btn       (btn),
    .led       (led),
    .hex_val   (hex_val)
  );

  always #5 clk = ~clk;

  // Synchronous-read block RAM model, 256 words.
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_addr[7:0]] <= bram_din;
    bram_dout <= bram_mem[bram_addr[7:0]];
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic exp_we);
    @(negedge clk);
    mem_addr  = addr;
    writedata = data;
    MEM_WR_S  = 1'b1;
    #1;
    check("bram_we", 16'(bram_we), 16'(exp_we));
    check("bram_addr", bram_addr, addr);
    check("bram_din", bram_din, data);
    @(posedge clk);
    #1;
    MEM_WR_S = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    mem_addr = addr;
    MEM_WR_S = 1'b0;
    @(posedge clk);
    #1;
    data = mem_out;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bram_mem[i] = '0;
    reset     = 1'b0;
    mem_addr  = 16'h0040;
    writedata = '0;
    MEM_WR_S  = 1'b1;
    sw        = '0;
    btn       = '0;
    #1;
    check("rst_led", 16'(led), 16'h0000);
    check("rst_hex", hex_val, 16'h0000);
    check("rst_bram_we_comb", 16'(bram_we), 16'h0001);
    MEM_WR_S = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // BRAM path
    bus_write(16'h0040, 16'h1234, 1'b1);
    bus_write(16'h0041, 16'h5678, 1'b1);
    bus_read(16'h0040, rd);  check("bram_rd_40", rd, 16'h1234);
    bus_read(16'h0041, rd);  check("bram_rd_41", rd, 16'h5678);

    // LED, truncation to NSW bits
    bus_write(16'hF000, 16'h03FF, 1'b0);
    check("led_port", 16'(led), 16'h03FF);
    bus_read(16'hF000, rd);  check("led_rd", rd, 16'h03FF);
    bus_write(16'hF000, 16'hFFFF, 1'b0);
    bus_read(16'hF000, rd);  check("led_trunc", rd, 16'h03FF);

    // HEX, aliasing, unmapped index, non-IO page
    bus_write(16'hF003, 16'hBEEF, 1'b0);
    check("hex_port", hex_val, 16'hBEEF);
    bus_read(16'hF013, rd);  check("hex_alias", rd, 16'hBEEF);
    bus_read(16'hF008, rd);  check("unmapped_rd", rd, 16'h0000);
    bus_read(16'hEF03, rd);  check("page_e_bram", rd, 16'h0000);

    // Switch synchroniser
    sw = 10'h2AA;
    repeat (3) @(posedge clk);
    bus_read(16'hF001, rd);  check("sw_rd", rd, 16'h02AA);

    // Button sticky edge flag and write-1-to-clear
    @(negedge clk);
    btn = 4'b0100;
    repeat (4) @(posedge clk);
    bus_read(16'hF002, rd);  check("btn_set", rd, 16'h0004);
    bus_write(16'hF002, 16'h0004, 1'b0);
    bus_read(16'hF002, rd);  check("btn_clr", rd, 16'h0000);
    btn = '0;

    // One-shot timer: TLOAD=3, EN=1
    bus_write(16'hF004, 16'h0003, 1'b0);
    bus_write(16'hF006, 16'h0001, 1'b0);
    mem_addr = 16'hF005;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = (k < 4) ? 16'd3 : (k < 8) ? 16'd2 : (k < 12) ? 16'd1 : 16'd0;
      check("oneshot_tcount", mem_out, exp_cnt);
    end
    bus_read(16'hF006, rd);  check("oneshot_tctrl", rd, 16'h8000);
    bus_read(16'hF005, rd);  check("oneshot_hold", rd, 16'h0000);
    bus_read(16'hF004, rd);  check("tload_rd", rd, 16'h0003);

    // Auto-reload timer; EXP cleared in the same write
    bus_write(16'hF006, 16'h8003, 1'b0);
    mem_addr = 16'hF005;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = (k < 4) ? 16'd3 : (k < 8) ? 16'd2 : (k < 12) ? 16'd1 : (k < 16) ? 16'd3 : 16'd2;
      check("auto_tcount", mem_out, exp_cnt);
    end
    bus_read(16'hF006, rd);  check("auto_tctrl", rd, 16'h8003);
    bus_write(16'hF006, 16'h8000, 1'b0);
    bus_read(16'hF006, rd);  check("exp_cleared", rd, 16'h0000);
    bus_read(16'hF005, rd);  check("frozen_tcount", rd, 16'h0002);
    repeat (5) @(posedge clk);
    bus_read(16'hF005, rd);  check("frozen_later", rd, 16'h0002);

    // Reset mid-countdown
    bus_write(16'hF000, 16'h0155, 1'b0);
    bus_write(16'hF004, 16'h0005, 1'b0);
    bus_write(16'hF006, 16'h0001, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_led", 16'(led), 16'h0000);
    check("midrst_hex", hex_val, 16'h0000);
    mem_addr = 16'hF007;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("cycle_restart", mem_out, 16'(k));
    end
    bus_read(16'hF005, rd);  check("midrst_tcount", rd, 16'h0000);
    bus_read(16'hF006, rd);  check("midrst_tctrl", rd, 16'h0000);
    bus_read(16'hF004, rd);  check("midrst_tload", rd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
